mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width.
REQ-002 Parameter DATA_W, default 64, data width (RV64).
REQ-003 Parameter STARVE_MAX, default 4, consecutive IF denials before IF is forced to win.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 if_req_i  in  1  instruction-fetch read request; if_addr_i  in  ADDR_W  fetch address.
REQ-007 if_flush_i  in  1  redirect; kills IF traffic (REQ-017).
REQ-008 if_gnt_o  out  1  IF request accepted this cycle.
REQ-009 if_rvalid_o  out  1  IF read data valid; if_rdata_o  out  DATA_W  IF read data.
REQ-010 ls_req_i  in  1  load/store request; ls_we_i  in  1  1 = write.
REQ-011 ls_addr_i  in  ADDR_W; ls_wdata_i  in  DATA_W; ls_wmask_i  in  DATA_W/8  byte enables.
REQ-012 ls_gnt_o  out  1; ls_rvalid_o  out  1; ls_rdata_o  out  DATA_W  load response.
REQ-013 mem_en_o  out  1; mem_we_o  out  1; mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W; mem_wmask_o  out  DATA_W/8  single-port memory command.
REQ-014 mem_rdata_i  in  DATA_W  memory read data, valid the cycle after a read command.

Function
REQ-015 One memory command per cycle max; grant is combinational in the request cycle; mem_* carries the granted master's fields in that same cycle, all zero when no grant.
REQ-016 Arbitration: LS wins over IF, except when starve_cnt == STARVE_MAX and if_req_i = 1, then IF wins.
REQ-017 if_flush_i = 1 in cycle T: if_gnt_o forced 0 in T (LS may be granted), and any IF response due in T is killed (if_rvalid_o = 0).
REQ-018 starve_cnt (width clog2(STARVE_MAX+1)): +1 when if_req_i = 1, no flush, and IF not granted; cleared when IF granted or if_req_i = 0; saturates at STARVE_MAX.
REQ-019 Response owner register resp_own ∈ {NONE, IF, LS}: set to IF on IF grant, LS on LS read grant, NONE otherwise (incl. LS write grant).
REQ-020 Cycle T+1 after a read grant in T: owner's rvalid = 1, owner's rdata = mem_rdata_i; other master's rvalid = 0, rdata = 0.
REQ-021 Read latency exactly 1 cycle; back-to-back grants every cycle allowed, with responses in grant order.
REQ-022 Writes complete at grant; no rvalid generated for writes.
REQ-023 Masters hold req and payload stable until gnt; the arbiter stores no request payload.
REQ-024 mem_addr_o passes the address unmodified; alignment is the master's responsibility.
REQ-025 if_rdata_o/ls_rdata_o = 0 whenever the respective rvalid = 0.

Reset
REQ-026 rst = 0 asynchronously clears starve_cnt to 0 and resp_own to NONE; all outputs 0 while rst = 0.
REQ-027 Reset asserted mid-transaction drops any pending response; no rvalid in the first cycle after release.
REQ-028 First grant possible in the first rising edge cycle after rst goes 1.

Verification
REQ-029 IF only: if_req_i = 1, addr 0x80000000, mem_rdata_i = 0x00000013 next cycle -> if_gnt_o = 1 in T, if_rvalid_o = 1 with if_rdata_o = 0x13 in T+1.
REQ-030 Simultaneous: if_req_i = ls_req_i = 1 (LS read 0x100) -> ls_gnt_o = 1, if_gnt_o = 0, mem_addr_o = 0x100; ls_rvalid_o = 1 in T+1.
REQ-031 Starvation: ls_req_i and if_req_i held 1 for 6 cycles -> LS granted cycles 0-3, IF granted cycle 4, LS cycle 5; starve_cnt back to 0 after cycle 4.
REQ-032 Write: ls_we_i = 1, addr 0x200, wdata 0xDEADBEEF, wmask 0x0F -> mem_we_o = 1, mem_wmask_o = 0x0F in T; no rvalid in T+1.
REQ-033 Flush: IF granted in T, if_flush_i = 1 in T+1 -> if_rvalid_o = 0 in T+1, if_gnt_o = 0 in T+1 even with if_req_i = 1.
REQ-034 Reset mid-op: LS read granted in T, rst = 0 in T+1 -> ls_rvalid_o = 0 throughout reset and in the first cycle after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter for a single-port memory.
// LS normally has priority; a starvation counter eventually forces an IF grant.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} own_t;

  own_t          resp_own, resp_own_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic          starved, if_win, ls_win;

  // Grants are qualified by rst so every output stays low while reset is held.
  assign starved = (starve_cnt == SMAX);
  assign if_win  = rst && if_req_i && !if_flush_i && (!ls_req_i || starved);
  assign ls_win  = rst && ls_req_i && !if_win;

  assign if_gnt_o = if_win;
  assign ls_gnt_o = ls_win;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (if_win) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end else if (ls_win) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
      mem_wmask_o = ls_wmask_i;
    end
  end

  // A flushed-but-requesting IF neither counts as denied nor clears the count.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!if_req_i || if_win)
      starve_nxt = '0;
    else if (!if_flush_i && !starved)
      starve_nxt = starve_cnt + 1'b1;
  end

  always_comb begin
    resp_own_nxt = OWN_NONE;
    if (if_win)
      resp_own_nxt = OWN_IF;
    else if (ls_win && !ls_we_i)
      resp_own_nxt = OWN_LS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      resp_own   <= OWN_NONE;
    end else begin
      starve_cnt <= starve_nxt;
      resp_own   <= resp_own_nxt;
    end
  end

  assign if_rvalid_o = (resp_own == OWN_IF) && !if_flush_i;
  assign ls_rvalid_o = (resp_own == OWN_LS);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: grants and memory command checked per
// vector, read responses tracked through an owner scoreboard queue.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i = 1'b0, if_flush_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [AW-1:0] ls_addr_i = '0;
  logic [DW-1:0] ls_wdata_i = '0;
  logic [7:0]    ls_wmask_i = '0;
  logic          ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] ls_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [7:0]    mem_wmask_o;
  logic [DW-1:0] mem_rdata_i = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef enum {E_NONE, E_IF, E_LS} own_e;
  typedef struct {
    logic          if_req, if_flush;
    logic [AW-1:0] if_addr;
    logic          ls_req, ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [7:0]    ls_wmask;
    logic [DW-1:0] mem_rdata;
    logic          exp_if_gnt, exp_ls_gnt;
  } vec_t;

  own_e sb[$];
  vec_t vt[22];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic ir, logic fl, logic [AW-1:0] ia, logic lr, logic lw,
                              logic [AW-1:0] la, logic [DW-1:0] wd, logic [7:0] wm,
                              logic [DW-1:0] rd, logic eig, logic elg);
    vec_t v;
    v.if_req = ir; v.if_flush = fl; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw;
    v.ls_addr = la; v.ls_wdata = wd; v.ls_wmask = wm; v.mem_rdata = rd;
    v.exp_if_gnt = eig; v.exp_ls_gnt = elg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " if_gnt"}, {63'd0, if_gnt_o}, 64'd0);
    chk({tag, " ls_gnt"}, {63'd0, ls_gnt_o}, 64'd0);
    chk({tag, " mem_en"}, {63'd0, mem_en_o}, 64'd0);
    chk({tag, " mem_addr"}, {32'd0, mem_addr_o}, 64'd0);
    chk({tag, " if_rvalid"}, {63'd0, if_rvalid_o}, 64'd0);
    chk({tag, " ls_rvalid"}, {63'd0, ls_rvalid_o}, 64'd0);
    chk({tag, " ls_rdata"}, ls_rdata_o, 64'd0);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply(input vec_t v, input int idx);
    own_e          own;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [7:0]    e_wm;
    string         t;
    t = $sformatf("v%0d", idx);
    if_req_i = v.if_req; if_flush_i = v.if_flush; if_addr_i = v.if_addr;
    ls_req_i = v.ls_req; ls_we_i = v.ls_we; ls_addr_i = v.ls_addr;
    ls_wdata_i = v.ls_wdata; ls_wmask_i = v.ls_wmask; mem_rdata_i = v.mem_rdata;
    #2;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_wm = '0;
    if (v.exp_if_gnt) begin
      e_en = 1'b1; e_addr = v.if_addr;
    end else if (v.exp_ls_gnt) begin
      e_en = 1'b1; e_we = v.ls_we; e_addr = v.ls_addr; e_wd = v.ls_wdata; e_wm = v.ls_wmask;
    end
    chk({t, " if_gnt"}, {63'd0, if_gnt_o}, {63'd0, v.exp_if_gnt});
    chk({t, " ls_gnt"}, {63'd0, ls_gnt_o}, {63'd0, v.exp_ls_gnt});
    chk({t, " mem_en"}, {63'd0, mem_en_o}, {63'd0, e_en});
    chk({t, " mem_we"}, {63'd0, mem_we_o}, {63'd0, e_we});
    chk({t, " mem_addr"}, {32'd0, mem_addr_o}, {32'd0, e_addr});
    chk({t, " mem_wdata"}, mem_wdata_o, e_wd);
    chk({t, " mem_wmask"}, {56'd0, mem_wmask_o}, {56'd0, e_wm});
    own = (sb.size() > 0) ? sb.pop_front() : E_NONE;
    if (v.if_flush && own == E_IF) own = E_NONE;
    chk({t, " if_rvalid"}, {63'd0, if_rvalid_o}, {63'd0, own == E_IF});
    chk({t, " if_rdata"}, if_rdata_o, (own == E_IF) ? v.mem_rdata : 64'd0);
    chk({t, " ls_rvalid"}, {63'd0, ls_rvalid_o}, {63'd0, own == E_LS});
    chk({t, " ls_rdata"}, ls_rdata_o, (own == E_LS) ? v.mem_rdata : 64'd0);
    if (v.exp_if_gnt) sb.push_back(E_IF);
    else if (v.exp_ls_gnt && !v.ls_we) sb.push_back(E_LS);
    else sb.push_back(E_NONE);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //            ir fl if_addr        lr lw ls_addr   wdata          wm     mem_rdata  eig elg
    vt[0]  = mk(1, 0, 32'h8000_0000, 0, 0, 32'h0,   64'h0,         8'h00, 64'h0,     1, 0);
    vt[1]  = mk(0, 0, 32'h0,         0, 0, 32'h0,   64'h0,         8'h00, 64'h13,    0, 0);
    vt[2]  = mk(1, 0, 32'h8000_0004, 1, 0, 32'h100, 64'h0,         8'h00, 64'h1111,  0, 1);
    vt[3]  = mk(1, 0, 32'h8000_0004, 1, 0, 32'h100, 64'h0,         8'h00, 64'h2222,  0, 1);
    vt[4]  = mk(1, 0, 32'h8000_0004, 1, 0, 32'h100, 64'h0,         8'h00, 64'h3333,  0, 1);
    vt[5]  = mk(1, 0, 32'h8000_0004, 1, 0, 32'h100, 64'h0,         8'h00, 64'h4444,  0, 1);
    vt[6]  = mk(1, 0, 32'h8000_0004, 1, 0, 32'h100, 64'h0,         8'h00, 64'h5555,  1, 0);
    vt[7]  = mk(1, 0, 32'h8000_0008, 1, 0, 32'h100, 64'h0,         8'h00, 64'h6666,  0, 1);
    vt[8]  = mk(0, 0, 32'h0,         0, 0, 32'h0,   64'h0,         8'h00, 64'h7777,  0, 0);
    vt[9]  = mk(0, 0, 32'h0,         1, 1, 32'h200, 64'hDEADBEEF,  8'h0F, 64'h0,     0, 1);
    vt[10] = mk(0, 0, 32'h0,         0, 0, 32'h0,   64'h0,         8'h00, 64'hAAAA,  0, 0);
    vt[11] = mk(1, 0, 32'h8000_0010, 0, 0, 32'h0,   64'h0,         8'h00, 64'h0,     1, 0);
    vt[12] = mk(1, 1, 32'h8000_0010, 0, 0, 32'h0,   64'h0,         8'h00, 64'h55,    0, 0);
    vt[13] = mk(1, 0, 32'h8000_0020, 1, 0, 32'h140, 64'h0,         8'h00, 64'h0,     0, 1);
    vt[14] = mk(1, 0, 32'h8000_0020, 1, 0, 32'h148, 64'h0,         8'h00, 64'hA1,    0, 1);
    vt[15] = mk(1, 0, 32'h8000_0020, 1, 0, 32'h150, 64'h0,         8'h00, 64'hA2,    0, 1);
    vt[16] = mk(1, 0, 32'h8000_0020, 1, 0, 32'h158, 64'h0,         8'h00, 64'hA3,    0, 1);
    vt[17] = mk(1, 1, 32'h8000_0020, 1, 0, 32'h160, 64'h0,         8'h00, 64'hA4,    0, 1);
    vt[18] = mk(1, 0, 32'h8000_0020, 1, 0, 32'h168, 64'h0,         8'h00, 64'hA5,    1, 0);
    vt[19] = mk(0, 0, 32'h0,         1, 1, 32'h170, 64'h0123_4567_89AB_CDEF, 8'hF0, 64'hA6, 0, 1);
    vt[20] = mk(0, 0, 32'h0,         0, 0, 32'h0,   64'h0,         8'h00, 64'hA7,    0, 0);
    vt[21] = mk(0, 0, 32'h0,         1, 0, 32'h300, 64'h0,         8'h00, 64'h0,     0, 1);

    // Reset held with both masters requesting: everything must stay quiet.
    if_req_i = 1'b1; ls_req_i = 1'b1; if_addr_i = 32'h1234; ls_addr_i = 32'h5678;
    mem_rdata_i = 64'hFFFF;
    repeat (3) @(negedge clk);
    #2 chk_idle("reset");
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(E_NONE);

    for (int i = 0; i < 22; i++) apply(vt[i], i);

    // Reset asserted in the cycle after an LS read grant (vt[21]).
    rst = 1'b0;
    mem_rdata_i = 64'h77;
    #2 chk_idle("midrst");
    repeat (2) @(negedge clk);
    #2 chk_idle("midrst_hold");
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    sb.push_back(E_NONE);
    apply(mk(0, 0, 32'h0, 1, 0, 32'h308, 64'h0, 8'h00, 64'h99, 0, 1), 100);
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0,   64'h0, 8'h00, 64'h42, 0, 0), 101);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
